// File: rtl/hc4_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// hc4_pkg - shared sizing and arbiter state type for the HC4 data RAM (rev 1.0)
// -----------------------------------------------------------------------------
package hc4_pkg;

  localparam int HC4_RAM_ADDR_W   = 8;
  localparam int HC4_RAM_DATA_W   = 4;
  localparam int HC4_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_FORCE = 2'd2,
    ARB_ACK   = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/hc4_ram_256x4.sv
`default_nettype none
// -----------------------------------------------------------------------------
// hc4_ram_256x4 - async-read/sync-write RAM with registered host read capture (rev 1.0)
// -----------------------------------------------------------------------------
module hc4_ram_256x4 #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cap_en,
  input  logic [ADDR_W-1:0] cap_addr,
  output logic [DATA_W-1:0] cap_data
);

  // Array contents intentionally survive nReset.
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] cap_data_q, cap_data_d;

  assign rd_data  = mem_q[rd_addr];
  assign cap_data = cap_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    cap_data_d = cap_data_q;
    if (cap_en) begin
      cap_data_d = mem_q[cap_addr];
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cap_data_q <= '0;
    end else begin
      cap_data_q <= cap_data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hc4_ram_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// hc4_ram_arbiter - shares the HC4 data RAM between the core and a host port (rev 1.0)
// -----------------------------------------------------------------------------
module hc4_ram_arbiter
  import hc4_pkg::*;
#(
  parameter int ADDR_W       = HC4_RAM_ADDR_W,
  parameter int DATA_W       = HC4_RAM_DATA_W,
  parameter int STARVE_LIMIT = HC4_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata
);

  localparam int               CNT_W    = $clog2(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              cpu_req;
  logic              host_go;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  assign cpu_req   = cpu_re | cpu_we;
  assign cpu_stall = (state_q == ARB_FORCE);
  assign host_ack  = (state_q == ARB_ACK);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    host_go      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (host_req) begin
          if (!cpu_req) begin
            host_go = 1'b1;
            state_d = ARB_ACK;
          end else begin
            state_d      = ARB_WAIT;
            starve_cnt_d = CNT_ONE;
          end
        end
      end
      ARB_WAIT: begin
        if (!host_req) begin
          state_d      = ARB_IDLE;
          starve_cnt_d = '0;
        end else if (!cpu_req) begin
          host_go = 1'b1;
          state_d = ARB_ACK;
        end else if (starve_cnt_q == CNT_LAST) begin
          state_d = ARB_FORCE;
        end else begin
          starve_cnt_d = starve_cnt_q + CNT_ONE;
        end
      end
      ARB_FORCE: begin
        host_go = 1'b1;
        state_d = ARB_ACK;
      end
      ARB_ACK: begin
        starve_cnt_d = '0;
        state_d      = ARB_IDLE;
      end
      default: begin
        state_d      = ARB_IDLE;
        starve_cnt_d = '0;
      end
    endcase
  end

  // Host only gets the write port when the core is absent or stalled.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cpu_addr;
    ram_wdata = cpu_wdata;
    if (host_go && host_we) begin
      ram_we    = 1'b1;
      ram_waddr = host_addr;
      ram_wdata = host_wdata;
    end else if (cpu_we && !cpu_stall) begin
      ram_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= ARB_IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  hc4_ram_256x4 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk      (clk),
    .nReset   (nReset),
    .rd_addr  (cpu_addr),
    .rd_data  (cpu_rdata),
    .we       (ram_we),
    .wr_addr  (ram_waddr),
    .wr_data  (ram_wdata),
    .cap_en   (host_go & ~host_we),
    .cap_addr (host_addr),
    .cap_data (host_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_hc4_ram_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_hc4_ram_arbiter - vector table, corner sequences and random model check (rev 1.0)
// -----------------------------------------------------------------------------
module tb_hc4_ram_arbiter;

  localparam int LIM = 8;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       cpu_re, cpu_we;
  logic [7:0] cpu_addr;
  logic [3:0] cpu_wdata, cpu_rdata;
  logic       cpu_stall;
  logic       host_req, host_we;
  logic [7:0] host_addr;
  logic [3:0] host_wdata, host_rdata;
  logic       host_ack;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       cre, cwe;
    logic [7:0] caddr;
    logic [3:0] cwd;
    logic       hreq, hwe;
    logic [7:0] haddr;
    logic [3:0] hwd;
    logic       e_stall, e_ack;
    logic       c_crd;
    logic [3:0] e_crd;
    logic       c_hrd;
    logic [3:0] e_hrd;
  } vec_t;

  vec_t       vecs [7];
  logic [3:0] model [256];
  logic [3:0] exp_hrd;
  int         ack_at, stall_at, stall_cnt, bad, d, gap, busy;
  logic       seen, forced, access;

  always #5 clk = ~clk;

  hc4_ram_arbiter #(
    .ADDR_W       (8),
    .DATA_W       (4),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk        (clk),
    .nReset     (nReset),
    .cpu_re     (cpu_re),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set(input logic re, input logic we, input logic [7:0] a, input logic [3:0] wd);
    cpu_re    = re;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
  endtask

  task automatic host_set(input logic req, input logic we, input logic [7:0] a, input logic [3:0] wd);
    host_req   = req;
    host_we    = we;
    host_addr  = a;
    host_wdata = wd;
  endtask

  task automatic rand_cpu(input int busy_pct);
    int kind;
    cpu_addr  = 8'($urandom);
    cpu_wdata = 4'($urandom);
    if ($urandom_range(0, 99) < busy_pct) begin
      kind   = $urandom_range(0, 2);
      cpu_re = (kind != 1);
      cpu_we = (kind != 0);
    end else begin
      cpu_re = 1'b0;
      cpu_we = 1'b0;
    end
  endtask

  initial begin
    // {cpu re,we,addr,wdata | host req,we,addr,wdata | stall, ack | chk,cpu_rdata | chk,host_rdata}
    vecs[0] = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 8'h3C, 4'hA, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1, 8'h3C, 4'hA, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0};
    vecs[2] = '{1'b1, 1'b0, 8'h3C, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0, 4'h0};
    vecs[3] = '{1'b0, 1'b1, 8'h10, 4'h5, 1'b1, 1'b0, 8'h10, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h10, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 8'h10, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h5};
    vecs[6] = '{1'b1, 1'b0, 8'h10, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1, 4'h5};

    cpu_set(1'b0, 1'b0, 8'h00, 4'h0);
    host_set(1'b0, 1'b0, 8'h00, 4'h0);
    #12;
    check("reset cpu_stall", cpu_stall, 0);
    check("reset host_ack", host_ack, 0);
    check("reset host_rdata", host_rdata, 0);
    @(negedge clk);
    nReset = 1'b1;
    next_cycle();

    // Directed vector table: host write/CPU read-back, then CPU write racing a host read.
    for (int i = 0; i < 7; i++) begin
      cpu_set(vecs[i].cre, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd);
      host_set(vecs[i].hreq, vecs[i].hwe, vecs[i].haddr, vecs[i].hwd);
      @(negedge clk);
      check($sformatf("vec%0d cpu_stall", i), cpu_stall, vecs[i].e_stall);
      check($sformatf("vec%0d host_ack", i), host_ack, vecs[i].e_ack);
      if (vecs[i].c_crd) check($sformatf("vec%0d cpu_rdata", i), cpu_rdata, vecs[i].e_crd);
      if (vecs[i].c_hrd) check($sformatf("vec%0d host_rdata", i), host_rdata, vecs[i].e_hrd);
      next_cycle();
    end
    cpu_set(1'b0, 1'b0, 8'h00, 4'h0);
    next_cycle();

    // Starvation: CPU reads every cycle, host read of 0x20 must be forced through.
    cpu_set(1'b0, 1'b1, 8'h20, 4'h9);
    next_cycle();
    cpu_set(1'b1, 1'b0, 8'h20, 4'h0);
    host_set(1'b1, 1'b0, 8'h20, 4'h0);
    ack_at = -1; stall_at = -1; stall_cnt = 0; bad = 0;
    for (int n = 0; n < 20 && ack_at < 0; n++) begin
      @(negedge clk);
      if (cpu_stall) begin
        stall_cnt++;
        stall_at = n;
      end
      if (cpu_rdata !== 4'h9) bad++;
      if (host_ack) ack_at = n;
      next_cycle();
    end
    host_set(1'b0, 1'b0, 8'h00, 4'h0);
    cpu_set(1'b0, 1'b0, 8'h00, 4'h0);
    check("starve ack cycle", ack_at, 9);
    check("starve stall count", stall_cnt, 1);
    check("starve stall cycle", stall_at, 8);
    check("starve cpu_rdata bad cycles", bad, 0);
    check("starve host_rdata", host_rdata, 4'h9);
    next_cycle();

    // Forced host write collides with a CPU write to the same nibble.
    cpu_set(1'b0, 1'b1, 8'h40, 4'h7);
    host_set(1'b1, 1'b1, 8'h40, 4'h2);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = cpu_stall;
      next_cycle();
    end
    check("collide stall seen", seen, 1);
    cpu_set(1'b0, 1'b0, 8'h00, 4'h0);
    @(negedge clk);
    check("collide host_ack", host_ack, 1);
    next_cycle();
    host_set(1'b0, 1'b0, 8'h00, 4'h0);
    cpu_set(1'b1, 1'b0, 8'h40, 4'h0);
    @(negedge clk);
    check("collide ram 0x40", cpu_rdata, 4'h2);
    next_cycle();

    // Asynchronous reset while a host write waits.
    cpu_set(1'b0, 1'b1, 8'h60, 4'hC);
    next_cycle();
    cpu_set(1'b1, 1'b0, 8'h60, 4'h0);
    host_set(1'b1, 1'b1, 8'h60, 4'h3);
    for (int n = 0; n < 3; n++) next_cycle();
    #2;
    nReset = 1'b0;
    #1;
    check("wait-reset cpu_stall", cpu_stall, 0);
    check("wait-reset host_ack", host_ack, 0);
    check("wait-reset host_rdata", host_rdata, 0);
    host_set(1'b0, 1'b0, 8'h00, 4'h0);
    cpu_set(1'b0, 1'b0, 8'h00, 4'h0);
    @(negedge clk);
    nReset = 1'b1;
    next_cycle();
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (host_ack || cpu_stall) bad++;
      next_cycle();
    end
    check("wait-reset spurious ack/stall", bad, 0);
    cpu_set(1'b1, 1'b0, 8'h60, 4'h0);
    @(negedge clk);
    check("wait-reset ram 0x60", cpu_rdata, 4'hC);
    next_cycle();

    // Host abandons its request while waiting.
    cpu_set(1'b0, 1'b1, 8'h70, 4'hE);
    next_cycle();
    cpu_set(1'b1, 1'b0, 8'h70, 4'h0);
    host_set(1'b1, 1'b1, 8'h70, 4'h1);
    for (int n = 0; n < 3; n++) next_cycle();
    host_set(1'b0, 1'b1, 8'h70, 4'h1);
    cpu_set(1'b0, 1'b0, 8'h00, 4'h0);
    bad = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (host_ack || cpu_stall) bad++;
      next_cycle();
    end
    check("abort spurious ack/stall", bad, 0);
    cpu_set(1'b1, 1'b0, 8'h70, 4'h0);
    @(negedge clk);
    check("abort ram 0x70", cpu_rdata, 4'hE);
    next_cycle();

    // Random traffic against a reference model: host is served at the first
    // request-relative cycle with the core idle, or at offset LIM by force.
    host_set(1'b0, 1'b0, 8'h00, 4'h0);
    for (int a = 0; a < 256; a++) begin
      model[a] = 4'($urandom);
      cpu_set(1'b0, 1'b1, 8'(a), model[a]);
      next_cycle();
    end
    cpu_set(1'b0, 1'b0, 8'h00, 4'h0);
    exp_hrd = 4'h0;
    for (int t = 0; t < 80; t++) begin
      busy = (t % 2 == 1) ? 95 : 50;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        rand_cpu(busy);
        @(negedge clk);
        check("rand gap host_ack", host_ack, 0);
        check("rand gap cpu_rdata", cpu_rdata, model[cpu_addr]);
        if (cpu_we) model[cpu_addr] = cpu_wdata;
        next_cycle();
      end
      host_set(1'b1, 1'($urandom), 8'($urandom), 4'($urandom));
      d = 0;
      access = 1'b0;
      while (!access) begin
        rand_cpu(busy);
        @(negedge clk);
        forced = (d == LIM);
        access = forced || !(cpu_re || cpu_we);
        check($sformatf("rand t%0d d%0d cpu_stall", t, d), cpu_stall, forced);
        check($sformatf("rand t%0d d%0d host_ack", t, d), host_ack, 0);
        check($sformatf("rand t%0d d%0d cpu_rdata", t, d), cpu_rdata, model[cpu_addr]);
        if (access && !host_we) exp_hrd = model[host_addr];
        if (cpu_we && !forced) model[cpu_addr] = cpu_wdata;
        if (access && host_we) model[host_addr] = host_wdata;
        d++;
        next_cycle();
      end
      rand_cpu(busy);
      @(negedge clk);
      check($sformatf("rand t%0d ack", t), host_ack, 1);
      check($sformatf("rand t%0d ack cpu_stall", t), cpu_stall, 0);
      check($sformatf("rand t%0d host_rdata", t), host_rdata, exp_hrd);
      check($sformatf("rand t%0d ack cpu_rdata", t), cpu_rdata, model[cpu_addr]);
      if (cpu_we) model[cpu_addr] = cpu_wdata;
      next_cycle();
      host_set(1'b0, 1'b0, 8'h00, 4'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hc4_ram_arbiter.md
# hc4_ram_arbiter

Owns the HC4 256×4 data RAM and shares it between the HC4 core (priority port) and a host/debug port (loader, I/O bridge or test master). The core keeps single-cycle combinational read access; host accesses are slotted into cycles where the core does not touch RAM, and a starvation counter forces a host slot by stalling the core for one cycle. It sits between the core's address/data bus and the RAM array, replacing the core's private `ram` array.

## Interface
Parameters:
- ADDR_W, 8, RAM address width (256 nibbles)
- DATA_W, 4, RAM data width
- STARVE_LIMIT, 8, consecutive denied cycles before a forced host slot (≥2)

Ports:
- clk  in  1  clock; all state updates on posedge
- nReset  in  1  asynchronous, active-low reset
- cpu_re  in  1  core reads RAM this cycle
- cpu_we  in  1  core writes RAM this cycle
- cpu_addr  in  ADDR_W  core address
- cpu_wdata  in  DATA_W  core write data
- cpu_rdata  out  DATA_W  combinational ram[cpu_addr]
- cpu_stall  out  1  core must hold its instruction; its write this cycle is dropped
- host_req  in  1  host access request, held until host_ack
- host_we  in  1  1 = write, 0 = read; stable while host_req
- host_addr  in  ADDR_W  host address; stable while host_req
- host_wdata  in  DATA_W  host write data; stable while host_req
- host_ack  out  1  one-cycle pulse: host access completed
- host_rdata  out  DATA_W  read data, valid while host_ack=1, held afterwards

## Operation
- cpu_req = cpu_re | cpu_we. CPU access always performed unless cpu_stall=1.
- States: IDLE, WAIT, FORCE, ACK.
- IDLE: host_req=0 → stay. host_req & !cpu_req → host access at this edge, → ACK. host_req & cpu_req → WAIT, starve_cnt=1.
- WAIT: !cpu_req → host access at this edge, → ACK. cpu_req & starve_cnt==STARVE_LIMIT-1 → FORCE. Else starve_cnt+1, stay.
- FORCE: cpu_stall=1 (state decode, registered). cpu_we ignored; host access at this edge; → ACK.
- ACK: host_ack=1; host_req ignored this cycle; starve_cnt cleared; → IDLE.
- Host read: host_rdata ← ram[host_addr] at the access edge. Host write: ram[host_addr] ← host_wdata; host_rdata unchanged.
- Never two writes at one edge: host write only when CPU absent or stalled.
- host_req dropped in WAIT → IDLE, no access, no ack (abort allowed only before ack).
- starve_cnt width $clog2(STARVE_LIMIT); saturates by construction, never wraps.

## Timing
- Reset (async): state IDLE, starve_cnt 0, cpu_stall 0, host_ack 0, host_rdata 0. RAM contents not reset (undefined at power-up, preserved across nReset). Pending host request discarded; host reissues.
- cpu_rdata: zero-latency combinational, also during stall; CPU write visible on cpu_rdata after the posedge.
- Host latency: access edge k, host_ack high cycle k+1. Best case: request in IDLE with CPU idle → ack next cycle. Worst case: STARVE_LIMIT+1 cycles from request to ack.
- Minimum host throughput: one access per 2 cycles (ACK then IDLE).
- cpu_stall high exactly one cycle per forced slot; never two consecutive cycles.

## Structure
- Shared package hc4_pkg: arb_state_t enum (IDLE, WAIT, FORCE, ACK), HC4_RAM_ADDR_W=8, HC4_RAM_DATA_W=4, default STARVE_LIMIT.
- Sub-module hc4_ram_256x4: async read port (CPU), sync write port, plus registered-read capture for host; muxed single write port driven by the arbiter.

## Test plan
- Host write 0xA to addr 0x3C, CPU idle → host_ack next cycle; CPU read 0x3C → cpu_rdata 0xA.
- CPU writes 0x5 to 0x10, host reads 0x10 requested same cycle → CPU write lands, host_ack 2+ cycles later with host_rdata 0x5.
- cpu_re held high continuously, host read 0x20 → WAIT 7 cycles, FORCE with cpu_stall=1 one cycle, host_ack next, total 9 cycles (STARVE_LIMIT=8).
- CPU write 0x7 to 0x40 during FORCE while host writes 0x2 to 0x40 → RAM holds 0x2; CPU write dropped.
- nReset asserted in WAIT → state IDLE, no ack, cpu_stall 0, previously written RAM contents unchanged.
- host_req dropped in WAIT → no access, no host_ack, RAM unchanged.
